// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one LAT-stage bitwise logic unit (AND/OR/XOR/NAND) among N requesters.
// A result appears LAT edges after its grant; a held response (rsp_valid & !rsp_ready) freezes every stage and all grants.
module logic_unit_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int LAT = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [2*N-1:0]   req_op,
  input  logic [W*N-1:0]   req_a,
  input  logic [W*N-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             busy
);

  logic             advance;
  logic             found;
  logic [IDW-1:0]   winner;
  logic             accept;
  logic [1:0]       win_op;
  logic [W-1:0]     win_a;
  logic [W-1:0]     win_b;
  logic [W-1:0]     win_y;

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   vld_d;
  logic [IDW-1:0]   id_q [LAT];
  logic [W-1:0]     y_q  [LAT];
  logic             busy_q;

  // Only a result that is being held back can stall; an empty output slot always lets the pipe move.
  assign advance = !vld_q[LAT-1] || rsp_ready;

  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = !reset && advance && found && (winner == IDW'(i));
    end
  end

  assign accept = |(req_valid & req_ready);

  assign win_op = req_op[2*int'(winner) +: 2];
  assign win_a  = req_a[W*int'(winner) +: W];
  assign win_b  = req_b[W*int'(winner) +: W];

  always_comb begin
    case (win_op)
      2'b00:   win_y = win_a & win_b;
      2'b01:   win_y = win_a | win_b;
      2'b10:   win_y = win_a ^ win_b;
      default: win_y = ~(win_a & win_b);
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (advance) begin
      for (int k = LAT-1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
      end
      vld_d[0] = accept;
    end
    if (accept) begin
      ptr_d = winner;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q  <= IDW'(N-1);
      vld_q  <= '0;
      busy_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        id_q[k] <= '0;
        y_q[k]  <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      busy_q <= |vld_d;
      if (advance) begin
        for (int k = LAT-1; k >= 1; k--) begin
          id_q[k] <= id_q[k-1];
          y_q[k]  <= y_q[k-1];
        end
        // Stage-0 payload is left stale on a bubble; its valid bit is what matters.
        if (accept) begin
          id_q[0] <= winner;
          y_q[0]  <= win_y;
        end
      end
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign rsp_y     = y_q[LAT-1];
  assign busy      = busy_q;

endmodule
